// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - opcode/funct, ALU, writeback and instruction-class encodings
package decoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;

    typedef enum logic [2:0] {
        PATH_R_ALU   = 3'd0,
        PATH_SHIFT   = 3'd1,
        PATH_I_ALU   = 3'd2,
        PATH_LOAD    = 3'd3,
        PATH_STORE   = 3'd4,
        PATH_BRANCH  = 3'd5,
        PATH_JUMP    = 3'd6,
        PATH_ILLEGAL = 3'd7
    } path_t;

    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic [3:0] alu_control;
        logic       alu_src;
        logic       reg_write;
        logic       select_shamt;
        path_t      path;
    } ctrl_t;

    // Logical immediates are zero-extended, lui shifts into the upper half.
    function automatic logic [31:0] extend_imm(input logic [5:0] opcode, input logic [15:0] imm);
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: return {16'h0000, imm};
            OP_LUI:                   return {imm, 16'h0000};
            default:                  return {{16{imm[15]}}, imm};
        endcase
    endfunction

endpackage

// File: rtl/control_lut.sv
// rtl/control_lut.sv - combinational opcode/funct to control bundle decode
module control_lut
    import decoder_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    function automatic ctrl_t r_op(input logic [3:0] alu, input logic shift);
        ctrl_t c;
        c              = '0;
        c.reg_dst      = 1'b1;
        c.reg_write    = 1'b1;
        c.alu_control  = alu;
        c.select_shamt = shift;
        c.path         = shift ? PATH_SHIFT : PATH_R_ALU;
        return c;
    endfunction

    function automatic ctrl_t i_op(input logic [3:0] alu, input logic [1:0] wb);
        ctrl_t c;
        c             = '0;
        c.alu_src     = 1'b1;
        c.reg_write   = 1'b1;
        c.alu_control = alu;
        c.mem_to_reg  = wb;
        c.path        = PATH_I_ALU;
        return c;
    endfunction

    // Anything not matched falls through as an all-zero NOP tagged illegal.
    always_comb begin
        ctrl      = '0;
        ctrl.path = PATH_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ctrl = r_op(ALU_ADD, 1'b0);
                    FN_SUB:  ctrl = r_op(ALU_SUB, 1'b0);
                    FN_AND:  ctrl = r_op(ALU_AND, 1'b0);
                    FN_OR:   ctrl = r_op(ALU_OR,  1'b0);
                    FN_XOR:  ctrl = r_op(ALU_XOR, 1'b0);
                    FN_NOR:  ctrl = r_op(ALU_NOR, 1'b0);
                    FN_SLT:  ctrl = r_op(ALU_SLT, 1'b0);
                    FN_SLL:  ctrl = r_op(ALU_SLL, 1'b1);
                    FN_SRL:  ctrl = r_op(ALU_SRL, 1'b1);
                    FN_SRA:  ctrl = r_op(ALU_SRA, 1'b1);
                    default: ;
                endcase
            end
            OP_ADDI: ctrl = i_op(ALU_ADD, WB_ALU);
            OP_SLTI: ctrl = i_op(ALU_SLT, WB_ALU);
            OP_ANDI: ctrl = i_op(ALU_AND, WB_ALU);
            OP_ORI:  ctrl = i_op(ALU_OR,  WB_ALU);
            OP_XORI: ctrl = i_op(ALU_XOR, WB_ALU);
            OP_LUI:  ctrl = i_op(ALU_AND, WB_IMM);
            OP_LW: begin
                ctrl.alu_src     = 1'b1;
                ctrl.mem_read    = 1'b1;
                ctrl.mem_to_reg  = WB_MEM;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = ALU_ADD;
                ctrl.path        = PATH_LOAD;
            end
            OP_SW: begin
                ctrl.alu_src     = 1'b1;
                ctrl.mem_write   = 1'b1;
                ctrl.alu_control = ALU_ADD;
                ctrl.path        = PATH_STORE;
            end
            OP_BEQ: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
                ctrl.path        = PATH_BRANCH;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
                ctrl.path = PATH_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decoder_control.sv
// rtl/decoder_control.sv - registered instruction decoder and main control unit
module decoder_control
    import decoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] instr,
    output logic        RegDst,
    output logic        Jump,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  MemtoReg,
    output logic [3:0]  ALU_Control,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [31:0] imm_extended,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [25:0] jump_address,
    output logic [2:0]  path_index,
    output logic        decoder_done,
    output logic        select_shamt
);

    ctrl_t       ctrl;
    logic [31:0] imm_next;

    control_lut u_control_lut (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .ctrl   (ctrl)
    );

    assign imm_next = extend_imm(instr[31:26], instr[15:0]);

    // With en low only the done flag drops; the decoded word is held for the datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegDst       <= 1'b0;
            Jump         <= 1'b0;
            Branch       <= 1'b0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            MemtoReg     <= 2'b00;
            ALU_Control  <= 4'b0000;
            ALUSrc       <= 1'b0;
            RegWrite     <= 1'b0;
            imm_extended <= 32'h0;
            rs           <= 5'd0;
            rt           <= 5'd0;
            rd           <= 5'd0;
            shamt        <= 5'd0;
            jump_address <= 26'd0;
            path_index   <= 3'd0;
            decoder_done <= 1'b0;
            select_shamt <= 1'b0;
        end else if (en) begin
            RegDst       <= ctrl.reg_dst;
            Jump         <= ctrl.jump;
            Branch       <= ctrl.branch;
            MemRead      <= ctrl.mem_read;
            MemWrite     <= ctrl.mem_write;
            MemtoReg     <= ctrl.mem_to_reg;
            ALU_Control  <= ctrl.alu_control;
            ALUSrc       <= ctrl.alu_src;
            RegWrite     <= ctrl.reg_write;
            imm_extended <= imm_next;
            rs           <= instr[25:21];
            rt           <= instr[20:16];
            rd           <= instr[15:11];
            shamt        <= instr[10:6];
            jump_address <= instr[25:0];
            path_index   <= ctrl.path;
            decoder_done <= 1'b1;
            select_shamt <= ctrl.select_shamt;
        end else begin
            decoder_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_control.sv
// tb/tb_decoder_control.sv - randomized table-model bench for decoder_control
module tb_decoder_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] instr;
    logic        RegDst, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite;
    logic        decoder_done, select_shamt;
    logic [1:0]  MemtoReg;
    logic [3:0]  ALU_Control;
    logic [31:0] imm_extended;
    logic [4:0]  rs, rt, rd, shamt;
    logic [25:0] jump_address;
    logic [2:0]  path_index;

    int errors = 0;
    int checks = 0;

    decoder_control dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .instr        (instr),
        .RegDst       (RegDst),
        .Jump         (Jump),
        .Branch       (Branch),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemtoReg     (MemtoReg),
        .ALU_Control  (ALU_Control),
        .ALUSrc       (ALUSrc),
        .RegWrite     (RegWrite),
        .imm_extended (imm_extended),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shamt        (shamt),
        .jump_address (jump_address),
        .path_index   (path_index),
        .decoder_done (decoder_done),
        .select_shamt (select_shamt)
    );

    always #5 clk = ~clk;

    // Flag letters of the instruction table, one bit each.
    localparam int F_RD = 1, F_SRC = 2, F_MR = 4, F_MW = 8, F_RW = 16, F_BR = 32, F_JP = 64, F_SH = 128;

    typedef struct {
        int op;
        int fn;
        int alu;
        int path;
        int wb;
        int flags;
    } row_t;

    row_t tbl[$];

    // Expected register image.
    int          e_flags, e_alu, e_path, e_wb;
    logic [31:0] e_imm;
    logic [31:0] e_word;
    logic        e_done;

    function automatic void add_row(int op, int fn, int alu, int path, int wb, int flags);
        row_t r;
        r.op = op; r.fn = fn; r.alu = alu; r.path = path; r.wb = wb; r.flags = flags;
        tbl.push_back(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (instr 0x%08h)", tag, obs, exp, e_word);
        end
    endtask

    task automatic model_reset();
        e_flags = 0; e_alu = 0; e_path = 0; e_wb = 0;
        e_imm = 0; e_word = 0; e_done = 0;
    endtask

    task automatic model_decode(input logic [31:0] w);
        int op, fn, lo;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        lo = int'(w[15:0]);
        e_flags = 0; e_alu = 0; e_wb = 0; e_path = 7;
        foreach (tbl[i]) begin
            if (tbl[i].op == op && (tbl[i].fn < 0 || tbl[i].fn == fn)) begin
                e_flags = tbl[i].flags; e_alu = tbl[i].alu;
                e_path = tbl[i].path; e_wb = tbl[i].wb;
            end
        end
        if (op == 'h0C || op == 'h0D || op == 'h0E) e_imm = 32'(lo);
        else if (op == 'h0F)                        e_imm = 32'(lo) * 32'h10000;
        else if (lo >= 32768)                       e_imm = 32'(lo) - 32'h10000;
        else                                        e_imm = 32'(lo);
        e_word = w;
        e_done = 1'b1;
    endtask

    task automatic check_all();
        check("RegDst",       RegDst,       ((e_flags & F_RD)  != 0));
        check("ALUSrc",       ALUSrc,       ((e_flags & F_SRC) != 0));
        check("MemRead",      MemRead,      ((e_flags & F_MR)  != 0));
        check("MemWrite",     MemWrite,     ((e_flags & F_MW)  != 0));
        check("RegWrite",     RegWrite,     ((e_flags & F_RW)  != 0));
        check("Branch",       Branch,       ((e_flags & F_BR)  != 0));
        check("Jump",         Jump,         ((e_flags & F_JP)  != 0));
        check("select_shamt", select_shamt, ((e_flags & F_SH)  != 0));
        check("MemtoReg",     MemtoReg,     e_wb);
        check("ALU_Control",  ALU_Control,  e_alu);
        check("path_index",   path_index,   e_path);
        check("imm_extended", imm_extended, e_imm);
        check("rs",           rs,           (e_word >> 21) % 32);
        check("rt",           rt,           (e_word >> 16) % 32);
        check("rd",           rd,           (e_word >> 11) % 32);
        check("shamt",        shamt,        (e_word >> 6) % 32);
        check("jump_address", jump_address, e_word % 32'h4000000);
        check("decoder_done", decoder_done, e_done);
    endtask

    // Drive between edges, clock once, then compare 1 time unit after the edge.
    task automatic step(input logic en_v, input logic [31:0] w);
        en = en_v;
        instr = w;
        @(posedge clk);
        if (en_v) model_decode(w);
        else      e_done = 1'b0;
        #1;
        check_all();
    endtask

    int legal_ops[11] = '{'h02, 'h04, 'h08, 'h0A, 'h0C, 'h0D, 'h0E, 'h0F, 'h23, 'h2B, 'h00};
    int legal_fns[10] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h00, 'h02, 'h03};

    initial begin
        logic [31:0] w;
        add_row('h00, 'h20, 2,  0, 0, F_RD | F_RW);
        add_row('h00, 'h22, 6,  0, 0, F_RD | F_RW);
        add_row('h00, 'h24, 0,  0, 0, F_RD | F_RW);
        add_row('h00, 'h25, 1,  0, 0, F_RD | F_RW);
        add_row('h00, 'h26, 3,  0, 0, F_RD | F_RW);
        add_row('h00, 'h27, 4,  0, 0, F_RD | F_RW);
        add_row('h00, 'h2A, 7,  0, 0, F_RD | F_RW);
        add_row('h00, 'h00, 8,  1, 0, F_RD | F_RW | F_SH);
        add_row('h00, 'h02, 9,  1, 0, F_RD | F_RW | F_SH);
        add_row('h00, 'h03, 10, 1, 0, F_RD | F_RW | F_SH);
        add_row('h08, -1,   2,  2, 0, F_SRC | F_RW);
        add_row('h0A, -1,   7,  2, 0, F_SRC | F_RW);
        add_row('h0C, -1,   0,  2, 0, F_SRC | F_RW);
        add_row('h0D, -1,   1,  2, 0, F_SRC | F_RW);
        add_row('h0E, -1,   3,  2, 0, F_SRC | F_RW);
        add_row('h0F, -1,   0,  2, 2, F_SRC | F_RW);
        add_row('h23, -1,   2,  3, 1, F_SRC | F_MR | F_RW);
        add_row('h2B, -1,   2,  4, 0, F_SRC | F_MW);
        add_row('h04, -1,   6,  5, 0, F_BR);
        add_row('h02, -1,   0,  6, 0, F_JP);

        reset = 1'b1; en = 1'b0; instr = 32'h0;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) step(1'b0, 32'h8B880000);
        step(1'b1, 32'h8B880000);
        check("illegal_rs", rs, 32'h1C);
        check("illegal_rt", rt, 32'h08);
        check("illegal_path", path_index, 32'd7);
        check("illegal_done", decoder_done, 32'd1);

        step(1'b1, 32'h00221820);
        check("add_alu", ALU_Control, 32'b0010);
        check("add_rd", rd, 32'd3);
        step(1'b1, 32'h000520C0);
        check("sll_alu", ALU_Control, 32'b1000);
        check("sll_shamt", shamt, 32'd3);
        step(1'b1, 32'h8D28FFFC);
        check("lw_imm", imm_extended, 32'hFFFFFFFC);
        check("lw_wb", MemtoReg, 32'b01);
        step(1'b1, 32'h34028001);
        check("ori_imm", imm_extended, 32'h00008001);
        check("ori_alu", ALU_Control, 32'b0001);
        step(1'b1, 32'h3C0F1234);
        check("lui_imm", imm_extended, 32'h12340000);
        step(1'b1, 32'h08000100);
        check("j_addr", jump_address, 32'h0000100);
        check("j_jump", Jump, 32'd1);

        step(1'b0, 32'hFFFFFFFF);
        check("hold_done", decoder_done, 32'd0);
        check("hold_addr", jump_address, 32'h0000100);

        step(1'b1, 32'h8D28FFFC);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("async_imm", imm_extended, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            w = $urandom;
            if (r < 4) begin
                w[31:26] = 6'h00;
                if (r < 3) w[5:0] = 6'(legal_fns[$urandom_range(0, 9)]);
            end else if (r < 9) begin
                w[31:26] = 6'(legal_ops[$urandom_range(0, 9)]);
            end
            step($urandom_range(0, 3) != 0, w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decoder_control.md
Name: decoder_control

Overview:
- Registered instruction decoder and main control unit for the single-issue MIPS-subset datapath on the Basys3 board.
- Sits between the instruction register and the register file, ALU, data memory and PC logic.
- When enabled, splits the 32-bit instruction into its fields, produces the extended immediate, generates every datapath control signal and the ALU operation code, and raises a done flag for the sequencer.

Parameters:
- None. The opcode, funct and ALU encodings are constants in a shared package.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  decode enable; a decode happens on every rising edge while en is high.
- instr  in  32  instruction word.
- RegDst  out  1  write-register select: 1 selects rd, 0 selects rt.
- Jump  out  1  select jump target for the PC.
- Branch  out  1  conditional branch (beq).
- MemRead  out  1  data memory read enable.
- MemWrite  out  1  data memory write enable.
- MemtoReg  out  2  writeback select: 00 ALU, 01 memory, 10 imm_extended, 11 reserved.
- ALU_Control  out  4  ALU operation.
- ALUSrc  out  1  ALU operand B select: 1 selects imm_extended, 0 selects rt data.
- RegWrite  out  1  register file write enable.
- imm_extended  out  32  extended immediate.
- rs, rt, rd, shamt  out  5 each  fields instr[25:21], [20:16], [15:11], [10:6].
- jump_address  out  26  instr[25:0].
- path_index  out  3  instruction class: 0 R-ALU, 1 shift, 2 I-ALU, 3 load, 4 store, 5 branch, 6 jump, 7 illegal.
- decoder_done  out  1  outputs valid.
- select_shamt  out  1  ALU operand A select: 1 selects shamt.

Behaviour:
- All outputs are registered.
- Reset asserted: every output is cleared to 0 asynchronously. This includes path_index and decoder_done.
- Rising edge with en=1: all outputs load from a combinational decode of instr, and decoder_done is set to 1.
- Latency is one cycle.
- decoder_done stays high while en stays high.
- Rising edge with en=0: decoder_done is cleared to 0, and all other outputs hold their values.
- Field outputs (rs, rt, rd, shamt, jump_address) are always loaded from instr, whatever the opcode.
- ALU_Control encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010.
- Opcode 0x00 (R-type): RegDst=1, RegWrite=1. The funct field selects the operation:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt: path_index 0.
  - 0x00 sll, 0x02 srl, 0x03 sra: select_shamt=1, path_index 1.
  - Any other funct code is illegal.
- I-ALU instructions: ALUSrc=1, RegWrite=1, path_index 2.
  - 0x08 addi: ADD.
  - 0x0A slti: SLT.
  - 0x0C andi: AND.
  - 0x0D ori: OR.
  - 0x0E xori: XOR.
  - 0x0F lui: MemtoReg=10.
- 0x23 lw: ALUSrc=1, MemRead=1, MemtoReg=01, RegWrite=1, ADD, path_index 3.
- 0x2B sw: ALUSrc=1, MemWrite=1, ADD, path_index 4.
- 0x04 beq: Branch=1, SUB, path_index 5.
- 0x02 j: Jump=1, path_index 6.
- Immediate extension:
  - andi, ori, xori: zero-extend instr[15:0].
  - lui: {instr[15:0], 16'h0}.
  - All other opcodes: sign-extend instr[15:0].
- Illegal opcode or funct: every control output is 0, ALU_Control is 0000, path_index is 7, and decoder_done is still asserted. An illegal instruction therefore behaves as a NOP.
- Signals not named in a row above are 0.

Decomposition:
- Package decoder_pkg holds the opcode and funct localparams, the ALU_Control codes, the MemtoReg codes and the path_index codes.
- One natural sub-module, control_lut: a purely combinational decode from opcode and funct to the control bundle.
- The top level adds the immediate extension and the output registers.

Test Plan:
- Reset, then 0x8B880000 with en=0 for 5 cycles, then en=1:
  - Outputs stay 0 while en=0.
  - One edge after en rises: decoder_done=1, rs=0x1C, rt=0x08, path_index=7, all controls 0.
- 0x00221820 (add $3,$1,$2): RegDst=1, RegWrite=1, ALU_Control=0010, rs=1, rt=2, rd=3, path_index=0, ALUSrc=0.
- 0x000520C0 (sll $4,$5,3): select_shamt=1, shamt=3, ALU_Control=1000, RegDst=1, path_index=1.
- 0x8D28FFFC (lw $8,-4($9)): imm_extended=0xFFFFFFFC, MemRead=1, MemtoReg=01, ALUSrc=1, RegWrite=1, RegDst=0, path_index=3.
- 0x34028001 (ori) gives imm_extended=0x00008001 and ALU_Control=0001. 0x08000100 (j) gives Jump=1 and jump_address=0x0000100.
- Reset mid-operation and en toggling:
  - reset asserted between edges clears all outputs immediately.
  - Dropping en clears decoder_done on the next edge while the other outputs keep their last values.
